// File: rtl/ram_fifo_ctrl_pkg.sv
// Shared width offsets, output-buffer sizing and buffer-level encoding for ram_fifo_ctrl.
package ram_fifo_ctrl_pkg;

  // Pointers carry one wrap bit, count needs headroom for RAM depth plus the buffer.
  localparam int PTR_EXTRA_BITS = 1;
  localparam int CNT_EXTRA_BITS = 2;
  localparam int OUT_BUF_DEPTH  = 2;
  localparam int LEVEL_W        = $clog2(OUT_BUF_DEPTH + 1);

  typedef enum logic [LEVEL_W-1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_TWO   = 2'd2
  } buf_level_e;

endpackage

// File: rtl/ram_fifo_ctrl_if.sv
// Push and pop valid/ready streams of ram_fifo_ctrl; slave is the FIFO side, master the client side.
interface ram_fifo_ctrl_if #(
  parameter int DATA_WIDTH = 8
);

  logic                  s_valid;
  logic                  s_ready;
  logic [DATA_WIDTH-1:0] s_data;
  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;

  modport master (
    output s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_data
  );

  modport slave (
    input  s_valid, s_data, m_ready,
    output s_ready, m_valid, m_data
  );

endinterface

// File: rtl/ram_fifo_ctrl_skid.sv
// fifo_out_skid: 2-entry in-order output buffer fed by RAM read captures, presenting a FWFT pop stream.
module fifo_out_skid
  import ram_fifo_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [LEVEL_W-1:0]    level
);

  buf_level_e            state_q, state_d;
  logic [DATA_WIDTH-1:0] head_q, head_d;
  logic [DATA_WIDTH-1:0] tail_q, tail_d;
  logic                  pop;

  assign out_valid = (state_q != BUF_EMPTY) && !rst;
  assign out_data  = head_q;
  assign level     = state_q;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= BUF_EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

  // The controller never captures into a full buffer without a pop in the same cycle.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    case (state_q)
      BUF_EMPTY: begin
        if (in_valid) begin
          head_d  = in_data;
          state_d = BUF_ONE;
        end
      end
      BUF_ONE: begin
        case ({in_valid, pop})
          2'b10: begin
            tail_d  = in_data;
            state_d = BUF_TWO;
          end
          2'b01:   state_d = BUF_EMPTY;
          2'b11:   head_d  = in_data;
          default: state_d = BUF_ONE;
        endcase
      end
      BUF_TWO: begin
        if (pop) begin
          head_d = tail_q;
          if (in_valid) begin
            tail_d = in_data;
          end else begin
            state_d = BUF_ONE;
          end
        end
      end
      default: state_d = BUF_EMPTY;
    endcase
  end

endmodule

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller around a simple dual-port RAM with 1-cycle registered read and a FWFT output buffer.
// Optional feature macro: FIFO_ALMOST_FULL_EN (registered almost_full flag; tied low otherwise).
module ram_fifo_ctrl
  import ram_fifo_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int ADDR_WIDTH   = 7,
  parameter int AFULL_THRESH = 120
) (
  input  logic                             clk,
  input  logic                             rst,
  ram_fifo_ctrl_if.slave                   bus,
  output logic [ADDR_WIDTH+CNT_EXTRA_BITS-1:0] count,
  output logic                             almost_full,
  output logic                             wena,
  output logic [ADDR_WIDTH-1:0]            waddra,
  output logic [DATA_WIDTH-1:0]            dina,
  output logic                             renb,
  output logic [ADDR_WIDTH-1:0]            raddrb,
  input  logic [DATA_WIDTH-1:0]            doutb
);

  localparam int PTR_W = ADDR_WIDTH + PTR_EXTRA_BITS;
  localparam int CNT_W = ADDR_WIDTH + CNT_EXTRA_BITS;

  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic               pending;
  logic [LEVEL_W-1:0] buf_level;
  logic [2:0]         occupancy;
  logic               ram_empty;
  logic               ram_full;
  logic               push_fire;
  logic               pop_fire;
  logic               rd_issue;

  assign ram_empty = (wr_ptr == rd_ptr);
  assign ram_full  = (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]) &&
                     (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]);

  assign bus.s_ready = !rst && !ram_full;
  assign push_fire   = bus.s_valid && bus.s_ready;
  assign pop_fire    = bus.m_valid && bus.m_ready;

  // Buffer slots already claimed once this cycle's pop leaves; prefetch only into a free one.
  assign occupancy = 3'(buf_level) + 3'(pending) - 3'(pop_fire);
  assign rd_issue  = !rst && !ram_empty && (occupancy < 3'd2);

  assign wena   = push_fire;
  assign waddra = rst ? '0 : wr_ptr[ADDR_WIDTH-1:0];
  assign dina   = push_fire ? bus.s_data : '0;
  assign renb   = rd_issue;
  assign raddrb = rst ? '0 : rd_ptr[ADDR_WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      pending <= 1'b0;
      count   <= '0;
    end else begin
      if (push_fire) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_issue) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      pending <= rd_issue;
      count   <= count + CNT_W'(push_fire) - CNT_W'(pop_fire);
    end
  end

  // Clearing pending on reset is what drops a read still in flight.
  fifo_out_skid #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (pending),
    .in_data   (doutb),
    .out_valid (bus.m_valid),
    .out_ready (bus.m_ready),
    .out_data  (bus.m_data),
    .level     (buf_level)
  );

`ifdef FIFO_ALMOST_FULL_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      almost_full <= 1'b0;
    end else begin
      almost_full <= (count >= CNT_W'(AFULL_THRESH));
    end
  end
`else
  localparam int afull_thresh_unused = AFULL_THRESH;
  assign almost_full = 1'b0;
`endif

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Directed self-checking bench for ram_fifo_ctrl with a behavioural registered-read dual-port RAM.
module tb_ram_fifo_ctrl;

  localparam int DW = 8;
  localparam int AW = 7;
  localparam int TH = 120;
  localparam int CW = AW + 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [CW-1:0] count;
  logic          almost_full;
  logic          wena;
  logic [AW-1:0] waddra;
  logic [DW-1:0] dina;
  logic          renb;
  logic [AW-1:0] raddrb;
  logic [DW-1:0] doutb;
  logic [DW-1:0] mem [0:(1<<AW)-1];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ram_fifo_ctrl_if #(.DATA_WIDTH(DW)) bus ();

  ram_fifo_ctrl #(
    .DATA_WIDTH   (DW),
    .ADDR_WIDTH   (AW),
    .AFULL_THRESH (TH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus.slave),
    .count       (count),
    .almost_full (almost_full),
    .wena        (wena),
    .waddra      (waddra),
    .dina        (dina),
    .renb        (renb),
    .raddrb      (raddrb),
    .doutb       (doutb)
  );

  // Simple dual-port RAM: write port A, read port B with one registered cycle of latency.
  always @(posedge clk) begin
    if (wena) mem[waddra] <= dina;
    if (renb) doutb <= mem[raddrb];
  end

  task automatic do_reset();
    rst = 1'b1;
    bus.s_valid = 1'b0;
    bus.s_data = '0;
    bus.m_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.s_valid = 1'b0;
    bus.s_data = '0;
    bus.m_ready = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (bus.m_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_m_valid: got %b expected 0", bus.m_valid); end
    checks++;
    if (bus.s_ready !== 1'b0) begin failures++; $display("[TB] FAIL reset_s_ready: got %b expected 0", bus.s_ready); end
    checks++;
    if (count !== '0) begin failures++; $display("[TB] FAIL reset_count: got %0d expected 0", count); end
    checks++;
    if ({wena, renb, almost_full} !== 3'b000) begin failures++; $display("[TB] FAIL reset_enables: got %b expected 000", {wena, renb, almost_full}); end
    checks++;
    if ({waddra, raddrb, dina} !== '0) begin failures++; $display("[TB] FAIL reset_ram_ports: got %h expected 0", {waddra, raddrb, dina}); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (bus.s_ready !== 1'b1) begin failures++; $display("[TB] FAIL post_reset_s_ready: got %b expected 1", bus.s_ready); end
  endtask

  task automatic test_single();
    do_reset();
    bus.s_valid = 1'b1;
    bus.s_data = 8'h5A;
    bus.m_ready = 1'b1;
    #1;
    checks++;
    if ({wena, waddra, dina} !== {1'b1, 7'd0, 8'h5A}) begin failures++; $display("[TB] FAIL single_write_port: got %h expected %h", {wena, waddra, dina}, {1'b1, 7'd0, 8'h5A}); end
    @(negedge clk);
    bus.s_valid = 1'b0;
    bus.s_data = '0;
    #1;
    checks++;
    if ({bus.m_valid, renb, raddrb} !== {1'b0, 1'b1, 7'd0}) begin failures++; $display("[TB] FAIL single_read_issue: got %h expected %h", {bus.m_valid, renb, raddrb}, {1'b0, 1'b1, 7'd0}); end
    checks++;
    if (count !== CW'(1)) begin failures++; $display("[TB] FAIL single_count_one: got %0d expected 1", count); end
    @(negedge clk);
    #1;
    checks++;
    if (bus.m_valid !== 1'b0) begin failures++; $display("[TB] FAIL single_early_valid: got %b expected 0", bus.m_valid); end
    @(negedge clk);
    #1;
    checks++;
    if ({bus.m_valid, bus.m_data} !== {1'b1, 8'h5A}) begin failures++; $display("[TB] FAIL single_pop_word: got %h expected %h", {bus.m_valid, bus.m_data}, {1'b1, 8'h5A}); end
    @(negedge clk);
    #1;
    checks++;
    if ({bus.m_valid, count} !== {1'b0, CW'(0)}) begin failures++; $display("[TB] FAIL single_after_pop: got %h expected 0", {bus.m_valid, count}); end
    bus.m_ready = 1'b0;
  endtask

  task automatic test_fill();
    int accepted = 0;
    int bad_wena = 0;
    do_reset();
    for (int cyc = 0; cyc < 160; cyc++) begin
      bus.s_valid = 1'b1;
      bus.s_data = DW'(accepted + 1);
      #1;
      if (!bus.s_ready && wena) bad_wena++;
      if (bus.s_ready) accepted++;
      @(negedge clk);
    end
    bus.s_valid = 1'b0;
    #1;
    checks++;
    if (accepted != 130) begin failures++; $display("[TB] FAIL fill_accepted: got %0d expected 130", accepted); end
    checks++;
    if (count !== CW'(130)) begin failures++; $display("[TB] FAIL fill_count: got %0d expected 130", count); end
    checks++;
    if (bus.s_ready !== 1'b0) begin failures++; $display("[TB] FAIL fill_s_ready: got %b expected 0", bus.s_ready); end
    checks++;
    if (bad_wena != 0) begin failures++; $display("[TB] FAIL fill_wena_blocked: got %0d writes expected 0", bad_wena); end
  endtask

  task automatic test_drain();
    bus.m_ready = 1'b1;
    for (int i = 1; i <= 130; i++) begin
      #1;
      checks++;
      if ({bus.m_valid, bus.m_data} !== {1'b1, DW'(i)}) begin
        failures++;
        $display("[TB] FAIL drain_word_%0d: got %h expected %h", i, {bus.m_valid, bus.m_data}, {1'b1, DW'(i)});
      end
      @(negedge clk);
    end
    #1;
    checks++;
    if ({bus.m_valid, count} !== {1'b0, CW'(0)}) begin failures++; $display("[TB] FAIL drain_empty: got %h expected 0", {bus.m_valid, count}); end
    checks++;
    if (bus.s_ready !== 1'b1) begin failures++; $display("[TB] FAIL drain_s_ready: got %b expected 1", bus.s_ready); end
    bus.m_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] q[$];
    logic [DW-1:0] exp_word;
    int pushed = 0;
    int popped = 0;
    int cyc = 0;
    do_reset();
    while (popped < 300 && cyc < 2000) begin
      bus.s_valid = (pushed < 300);
      bus.s_data = DW'(pushed * 7 + 3);
      bus.m_ready = (pushed >= 64);
      #1;
      checks++;
      if (int'(count) != q.size()) begin failures++; $display("[TB] FAIL stream_count_c%0d: got %0d expected %0d", cyc, count, q.size()); end
      if (bus.m_valid && bus.m_ready) begin
        exp_word = q.pop_front();
        checks++;
        if (bus.m_data !== exp_word) begin failures++; $display("[TB] FAIL stream_word_%0d: got %h expected %h", popped, bus.m_data, exp_word); end
        popped++;
      end
      if (bus.s_valid && bus.s_ready) begin
        q.push_back(bus.s_data);
        pushed++;
      end
      @(negedge clk);
      cyc++;
    end
    bus.s_valid = 1'b0;
    bus.m_ready = 1'b0;
    #1;
    checks++;
    if (popped != 300) begin failures++; $display("[TB] FAIL stream_popped: got %0d expected 300", popped); end
    checks++;
    if ({bus.m_valid, count} !== {1'b0, CW'(0)}) begin failures++; $display("[TB] FAIL stream_empty: got %h expected 0", {bus.m_valid, count}); end
  endtask

  task automatic test_reset_mid();
    logic seen = 1'b0;
    do_reset();
    for (int k = 1; k <= 3; k++) begin
      bus.s_valid = 1'b1;
      bus.s_data = DW'(k * 8'h11);
      @(negedge clk);
    end
    bus.s_valid = 1'b0;
    #1;
    checks++;
    if ({bus.m_valid, count} !== {1'b1, CW'(3)}) begin failures++; $display("[TB] FAIL mid_pre_reset: got %h expected %h", {bus.m_valid, count}, {1'b1, CW'(3)}); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if ({bus.m_valid, count, bus.s_ready} !== {1'b0, CW'(0), 1'b1}) begin failures++; $display("[TB] FAIL mid_after_reset: got %h expected %h", {bus.m_valid, count, bus.s_ready}, {1'b0, CW'(0), 1'b1}); end
    bus.s_valid = 1'b1;
    bus.s_data = 8'hA5;
    bus.m_ready = 1'b1;
    @(negedge clk);
    bus.s_valid = 1'b0;
    for (int w = 0; w < 10 && !seen; w++) begin
      #1;
      if (bus.m_valid) seen = 1'b1;
      else @(negedge clk);
    end
    checks++;
    if ({seen, bus.m_data} !== {1'b1, 8'hA5}) begin failures++; $display("[TB] FAIL mid_first_pop: got %h expected %h", {seen, bus.m_data}, {1'b1, 8'hA5}); end
    @(negedge clk);
    #1;
    checks++;
    if ({bus.m_valid, count} !== {1'b0, CW'(0)}) begin failures++; $display("[TB] FAIL mid_no_stale: got %h expected 0", {bus.m_valid, count}); end
    bus.m_ready = 1'b0;
  endtask

  task automatic test_almost_full();
`ifdef FIFO_ALMOST_FULL_EN
    do_reset();
    for (int k = 0; k < 120; k++) begin
      bus.s_valid = 1'b1;
      bus.s_data = DW'(k);
      @(negedge clk);
    end
    bus.s_valid = 1'b0;
    #1;
    checks++;
    if ({count, almost_full} !== {CW'(120), 1'b0}) begin failures++; $display("[TB] FAIL af_at_120: got %h expected %h", {count, almost_full}, {CW'(120), 1'b0}); end
    @(negedge clk);
    #1;
    checks++;
    if (almost_full !== 1'b1) begin failures++; $display("[TB] FAIL af_set: got %b expected 1", almost_full); end
    bus.m_ready = 1'b1;
    @(negedge clk);
    bus.m_ready = 1'b0;
    #1;
    checks++;
    if ({count, almost_full} !== {CW'(119), 1'b1}) begin failures++; $display("[TB] FAIL af_at_119: got %h expected %h", {count, almost_full}, {CW'(119), 1'b1}); end
    @(negedge clk);
    #1;
    checks++;
    if (almost_full !== 1'b0) begin failures++; $display("[TB] FAIL af_clear: got %b expected 0", almost_full); end
`else
    int bad_af = 0;
    do_reset();
    for (int k = 0; k < 140; k++) begin
      bus.s_valid = 1'b1;
      bus.s_data = DW'(k);
      #1;
      if (almost_full !== 1'b0) bad_af++;
      @(negedge clk);
    end
    bus.s_valid = 1'b0;
    #1;
    checks++;
    if (bad_af != 0 || almost_full !== 1'b0) begin failures++; $display("[TB] FAIL af_tied_low: got %0d cycles high expected 0", bad_af); end
    checks++;
    if (count !== CW'(130)) begin failures++; $display("[TB] FAIL af_fill_count: got %0d expected 130", count); end
`endif
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    bus.s_valid = 1'b0;
    bus.s_data = '0;
    bus.m_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_single();
    test_fill();
    test_drain();
    test_back_to_back();
    test_reset_mid();
    test_almost_full();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
